// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester slice.
// The top optionally compiles in a watchdog under APB_REQUESTER_TIMEOUT_EN.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_req_state_t;

endpackage

// File: rtl/apb_requester_timeout_counter.sv
// apb_timeout_counter: watchdog for the ACCESS phase of the APB requester.
// Counts enabled cycles after a clear, saturates instead of wrapping, and
// flags expiry once the count reaches TIMEOUT_CYCLES-1.
// Only instantiated when APB_REQUESTER_TIMEOUT_EN is defined.
module apb_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CntW-1:0] CntMax = '1;
    localparam logic [CntW-1:0] CntExp = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count enabled cycles and saturate.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CntExp);

endmodule

// File: rtl/apb_requester.sv
// apb_requester: valid/ready command port to APB requester bridge.
// Single outstanding transfer sequenced IDLE -> SETUP -> ACCESS, with a
// one-cycle response strobe on completion.
// Define APB_REQUESTER_TIMEOUT_EN to compile in the ACCESS-phase watchdog;
// without it ACCESS waits for PREADY indefinitely and rsp_timeout stays 0.
module apb_requester
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W         = APB_ADDR_W,
    parameter int unsigned DATA_W         = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    // Command port
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic                cmd_write,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    // Response port
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_error,
    output logic                rsp_timeout,
    // APB requester
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic [DATA_W-1:0]   PWDATA,
    output logic [DATA_W/8-1:0] PSTRB,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY,
    input  logic                PERROR
);

    localparam int unsigned StrbW = DATA_W / 8;

    apb_req_state_t    state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [StrbW-1:0]  pstrb_q, pstrb_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_error_q, rsp_error_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    logic accept;
    logic timed_out;

    assign accept = cmd_valid && cmd_ready_q;

`ifdef APB_REQUESTER_TIMEOUT_EN
    logic expired;

    // Counter is cleared while in SETUP so it starts at zero on entry to ACCESS.
    apb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (PCLK),
        .rst_ni    (PRESETn),
        .clear_i   (state_q == SETUP),
        .en_i      ((state_q == ACCESS) && !PREADY),
        .expired_o (expired)
    );

    assign timed_out = expired && !PREADY && (state_q == ACCESS);
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timed_out          = 1'b0;
`endif

    // Next-state and output computation for the transfer sequencer.
    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            IDLE: begin
                // cmd_ready comes up one edge after reset release.
                cmd_ready_d = 1'b1;
                if (accept) begin
                    paddr_d     = cmd_addr;
                    pwrite_d    = cmd_write;
                    pwdata_d    = cmd_wdata;
                    pstrb_d     = cmd_write ? cmd_strb : '0;
                    psel_d      = 1'b1;
                    cmd_ready_d = 1'b0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    rsp_valid_d   = 1'b1;
                    rsp_error_d   = PERROR;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    cmd_ready_d   = 1'b1;
                    state_d       = IDLE;
                end else if (timed_out) begin
                    rsp_valid_d   = 1'b1;
                    rsp_error_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    cmd_ready_d   = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears the bus asynchronously.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_timeout = rsp_timeout_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PSTRB       = pstrb_q;

endmodule

// File: tb/tb_apb_requester.sv
// Directed self-checking bench for apb_requester (TIMEOUT_CYCLES = 8).
// Timeout expectations follow APB_REQUESTER_TIMEOUT_EN.
module tb_apb_requester;

    logic        PCLK;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        rsp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PERROR;

    int tests_run = 0;
    int fail_cnt  = 0;

    apb_requester #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_write   (cmd_write),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PSTRB       (PSTRB),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PERROR      (PERROR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;
    endtask

    task automatic test_reset();
        logic [106:0] all_out;
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PERROR    = 1'b0;
        #12;
        all_out = {cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout, PSEL, PENABLE,
                   PWRITE, PADDR, PWDATA, PSTRB};
        tests_run++;
        if (all_out !== '0) begin
            fail_cnt++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        // Command presented across release must not be taken before cmd_ready rises.
        PRESETn = 1'b1;
        issue(1'b1, 32'h0000_00F0, 32'h1111_1111, 4'hF);
        #1;
        tests_run++;
        if (cmd_ready !== 1'b0) begin
            fail_cnt++;
            $display("FAIL reset_ready_before_edge: got %b want 0", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        tests_run++;
        if ({cmd_ready, PSEL} !== 2'b10) begin
            fail_cnt++;
            $display("FAIL reset_ready_first_edge: ready,psel got %b want 10", {cmd_ready, PSEL});
        end
    endtask

    task automatic test_read_wait();
        PREADY = 1'b0;
        PRDATA = 32'hBAD0_BAD0;
        issue(1'b0, 32'h0000_0008, 32'hFFFF_0000, 4'hF);
        tick(); // e0
        cmd_valid = 1'b0;
        tests_run++;
        if ({PSEL, PENABLE, PWRITE, PSTRB, cmd_ready} !== 8'b100_0000_0) begin
            fail_cnt++;
            $display("FAIL rd_setup: psel,pen,pwr,strb,rdy got %b want 10000000",
                     {PSEL, PENABLE, PWRITE, PSTRB, cmd_ready});
        end
        tick(); // e1
        for (int i = 0; i < 3; i++) begin
            tick(); // e2..e4 with PREADY low
            tests_run++;
            if ({PSEL, PENABLE, PWRITE, PSTRB, rsp_valid, PADDR} !== {8'b110_0000_0, 32'h8}) begin
                fail_cnt++;
                $display("FAIL rd_wait%0d: psel,pen,pwr,strb,rsp,addr got %b %h want 11000000 8",
                         i, {PSEL, PENABLE, PWRITE, PSTRB, rsp_valid}, PADDR);
            end
        end
        PREADY = 1'b1;
        PRDATA = 32'h1234_5678;
        tick(); // e5
        PREADY = 1'b0;
        PRDATA = 32'hBAD0_BAD0;
        tests_run++;
        if ({rsp_valid, rsp_error, rsp_timeout, cmd_ready, PSEL, PENABLE} !== 6'b100100) begin
            fail_cnt++;
            $display("FAIL rd_complete: v,err,to,rdy,psel,pen got %b want 100100",
                     {rsp_valid, rsp_error, rsp_timeout, cmd_ready, PSEL, PENABLE});
        end
        tests_run++;
        if (rsp_rdata !== 32'h1234_5678) begin
            fail_cnt++;
            $display("FAIL rd_rdata: got %h want 12345678", rsp_rdata);
        end
        tick();
        tests_run++;
        if ({rsp_valid, rsp_rdata, PADDR} !== {1'b0, 32'h1234_5678, 32'h8}) begin
            fail_cnt++;
            $display("FAIL rd_hold: v,rdata,addr got %b %h %h want 0 12345678 8",
                     rsp_valid, rsp_rdata, PADDR);
        end
    endtask

    task automatic test_write_zero_wait();
        PREADY = 1'b1;
        issue(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF);
        tick(); // e0
        cmd_valid = 1'b0;
        tests_run++;
        if ({PSEL, PENABLE, PWRITE, PSTRB, PADDR, PWDATA} !== {7'b101_1111, 32'h4, 32'hDEAD_BEEF})
        begin
            fail_cnt++;
            $display("FAIL wr_setup: psel,pen,pwr,strb %b addr %h wdata %h want 1011111 4 deadbeef",
                     {PSEL, PENABLE, PWRITE, PSTRB}, PADDR, PWDATA);
        end
        tick(); // e1
        tests_run++;
        if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin
            fail_cnt++;
            $display("FAIL wr_access: psel,pen,rsp got %b want 110", {PSEL, PENABLE, rsp_valid});
        end
        tick(); // e2
        tests_run++;
        if ({rsp_valid, rsp_error, rsp_timeout, PSEL, PENABLE, cmd_ready, rsp_rdata}
            !== {6'b100001, 32'h0}) begin
            fail_cnt++;
            $display("FAIL wr_complete: v,err,to,psel,pen,rdy %b rdata %h want 100001 0",
                     {rsp_valid, rsp_error, rsp_timeout, PSEL, PENABLE, cmd_ready}, rsp_rdata);
        end
        tick();
        PREADY = 1'b0;
        tests_run++;
        if ({rsp_valid, PSEL, PWRITE, PSTRB, PWDATA} !== {7'b0011111, 32'hDEAD_BEEF}) begin
            fail_cnt++;
            $display("FAIL wr_idle_hold: v,psel,pwr,strb %b wdata %h want 0011111 deadbeef",
                     {rsp_valid, PSEL, PWRITE, PSTRB}, PWDATA);
        end
    endtask

    task automatic test_error();
        PREADY = 1'b1;
        PERROR = 1'b1;
        PRDATA = 32'h0000_00EE;
        issue(1'b0, 32'h0000_0040, 32'h0, 4'h0);
        tick(); // e0
        cmd_valid = 1'b0;
        tick(); // e1
        tick(); // e2
        PERROR = 1'b0;
        PREADY = 1'b0;
        tests_run++;
        if ({rsp_valid, rsp_error, rsp_timeout} !== 3'b110) begin
            fail_cnt++;
            $display("FAIL err_rsp: v,err,to got %b want 110", {rsp_valid, rsp_error, rsp_timeout});
        end
        tick();
        tests_run++;
        if ({rsp_valid, rsp_error} !== 2'b01) begin
            fail_cnt++;
            $display("FAIL err_hold: v,err got %b want 01", {rsp_valid, rsp_error});
        end
    endtask

    task automatic test_back_to_back();
        PREADY = 1'b1;
        PRDATA = 32'h0BAD_CAFE;
        issue(1'b1, 32'h0000_0010, 32'hAAAA_5555, 4'h3);
        tick(); // e0: first accepted
        issue(1'b0, 32'h0000_0014, 32'h0, 4'hF);
        tests_run++;
        if ({PSEL, cmd_ready, PADDR} !== {2'b10, 32'h10}) begin
            fail_cnt++;
            $display("FAIL b2b_first_accept: psel,rdy %b addr %h want 10 10", {PSEL, cmd_ready}, PADDR);
        end
        tick(); // e1: second command must be ignored
        tests_run++;
        if ({PADDR, PWRITE, PSTRB} !== {32'h10, 1'b1, 4'h3}) begin
            fail_cnt++;
            $display("FAIL b2b_ignored: addr %h pwr %b strb %h want 10 1 3", PADDR, PWRITE, PSTRB);
        end
        tick(); // e2: first completes
        tests_run++;
        if ({rsp_valid, cmd_ready, PSEL} !== 3'b110) begin
            fail_cnt++;
            $display("FAIL b2b_first_rsp: v,rdy,psel got %b want 110", {rsp_valid, cmd_ready, PSEL});
        end
        tick(); // e3: second accepted
        cmd_valid = 1'b0;
        tests_run++;
        if ({PSEL, PENABLE, cmd_ready, rsp_valid, PWRITE, PSTRB, PADDR}
            !== {9'b100000000, 32'h14}) begin
            fail_cnt++;
            $display("FAIL b2b_second_accept: psel,pen,rdy,v,pwr,strb %b addr %h want 100000000 14",
                     {PSEL, PENABLE, cmd_ready, rsp_valid, PWRITE, PSTRB}, PADDR);
        end
        tick(); // e4
        tick(); // e5
        PREADY = 1'b0;
        tests_run++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0BAD_CAFE}) begin
            fail_cnt++;
            $display("FAIL b2b_second_rsp: v %b rdata %h want 1 0badcafe", rsp_valid, rsp_rdata);
        end
        tick();
    endtask

    task automatic test_timeout();
        PREADY = 1'b0;
        PRDATA = 32'h55AA_55AA;
        issue(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        tick(); // e0
        cmd_valid = 1'b0;
        tick(); // e1
        for (int i = 0; i < 7; i++) begin
            tick(); // e2..e8
            tests_run++;
            if ({rsp_valid, PSEL, PENABLE} !== 3'b011) begin
                fail_cnt++;
                $display("FAIL to_wait%0d: v,psel,pen got %b want 011", i, {rsp_valid, PSEL, PENABLE});
            end
        end
        tick(); // e9
`ifdef APB_REQUESTER_TIMEOUT_EN
        tests_run++;
        if ({rsp_valid, rsp_error, rsp_timeout, PSEL, PENABLE, cmd_ready, rsp_rdata}
            !== {6'b111001, 32'h0}) begin
            fail_cnt++;
            $display("FAIL to_abort: v,err,to,psel,pen,rdy %b rdata %h want 111001 0",
                     {rsp_valid, rsp_error, rsp_timeout, PSEL, PENABLE, cmd_ready}, rsp_rdata);
        end
        tick();
        tests_run++;
        if ({rsp_valid, rsp_timeout} !== 2'b01) begin
            fail_cnt++;
            $display("FAIL to_hold: v,to got %b want 01", {rsp_valid, rsp_timeout});
        end
`else
        begin
            int bad = 0;
            for (int i = 0; i < 100; i++) begin
                if ({rsp_valid, PSEL, PENABLE} !== 3'b011) bad++;
                tick();
            end
            tests_run++;
            if (bad !== 0) begin
                fail_cnt++;
                $display("FAIL to_no_watchdog: cycles out of ACCESS got %0d want 0", bad);
            end
        end
        PREADY = 1'b1;
        tick();
        PREADY = 1'b0;
        tests_run++;
        if ({rsp_valid, rsp_error, rsp_timeout, rsp_rdata} !== {3'b100, 32'h55AA_55AA}) begin
            fail_cnt++;
            $display("FAIL to_late_ready: v,err,to %b rdata %h want 100 55aa55aa",
                     {rsp_valid, rsp_error, rsp_timeout}, rsp_rdata);
        end
        tick();
`endif
    endtask

    task automatic test_ready_on_expiry();
        PREADY = 1'b0;
        PRDATA = 32'h0;
        issue(1'b0, 32'h0000_0024, 32'h0, 4'h0);
        tick(); // e0
        cmd_valid = 1'b0;
        tick(); // e1
        repeat (7) tick(); // e2..e8
        PREADY = 1'b1;
        PRDATA = 32'hA5A5_A5A5;
        tick(); // e9
        PREADY = 1'b0;
        tests_run++;
        if ({rsp_valid, rsp_error, rsp_timeout, rsp_rdata} !== {3'b100, 32'hA5A5_A5A5}) begin
            fail_cnt++;
            $display("FAIL expiry_ready: v,err,to %b rdata %h want 100 a5a5a5a5",
                     {rsp_valid, rsp_error, rsp_timeout}, rsp_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [106:0] all_out;
        PREADY = 1'b0;
        issue(1'b1, 32'h0000_0030, 32'h7777_7777, 4'hC);
        tick(); // e0
        cmd_valid = 1'b0;
        tick(); // e1
        tick(); // e2, waiting in ACCESS
        #2;
        PRESETn = 1'b0;
        PREADY  = 1'b1;
        #1;
        all_out = {cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout, PSEL, PENABLE,
                   PWRITE, PADDR, PWDATA, PSTRB};
        tests_run++;
        if (all_out !== '0) begin
            fail_cnt++;
            $display("FAIL rst_mid_async: got %h want 0", all_out);
        end
        tick();
        tests_run++;
        if ({rsp_valid, PSEL, PENABLE, cmd_ready} !== 4'b0000) begin
            fail_cnt++;
            $display("FAIL rst_mid_held: v,psel,pen,rdy got %b want 0000",
                     {rsp_valid, PSEL, PENABLE, cmd_ready});
        end
        #3;
        PRESETn = 1'b1;
        tick();
        tests_run++;
        if ({cmd_ready, rsp_valid, PSEL} !== 3'b100) begin
            fail_cnt++;
            $display("FAIL rst_mid_release: rdy,v,psel got %b want 100", {cmd_ready, rsp_valid, PSEL});
        end
        tick();
        PREADY = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            fail_cnt++;
            $display("FAIL rst_mid_no_rsp: got %b want 0", rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_read_wait();
        test_write_zero_wait();
        test_error();
        test_back_to_back();
        test_timeout();
        test_ready_on_expiry();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule

// File: doc/apb_requester.md
# apb_requester

Bridge from a simple valid/ready command port to an APB requester. Each command is sequenced through the APB SETUP and ACCESS phases. The block waits on PREADY, then returns read data and error status on a one-cycle response strobe. It is the initiating end of the APB links that our memory-mapped peripherals (e.g. the 16×32 register/memory completer) sit on. Transfers are single-outstanding.

## Interface
- ADDR_W, 32, PADDR/cmd_addr width
- DATA_W, 32, data width; strobe width is DATA_W/8
- TIMEOUT_CYCLES, 64, ACCESS cycles with PREADY low before abort (used only with macro)

- PCLK  in  1  clock, all logic on rising edge
- PRESETn  in  1  reset; one clock, reset asynchronous and active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  block idle, command accepted when cmd_valid && cmd_ready
- cmd_addr  in  ADDR_W  target address
- cmd_write  in  1  1 = write, 0 = read
- cmd_wdata  in  DATA_W  write data
- cmd_strb  in  DATA_W/8  byte write strobes
- rsp_valid  out  1  one-cycle completion pulse, no backpressure
- rsp_rdata  out  DATA_W  captured PRDATA (reads); 0 on writes
- rsp_error  out  1  PERROR captured, or timeout
- rsp_timeout  out  1  transfer aborted by watchdog
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_W; PWDATA  out  DATA_W; PSTRB  out  DATA_W/8
- PRDATA  in  DATA_W; PREADY  in  1; PERROR  in  1  completer response

## Operation
- FSM states IDLE, SETUP, ACCESS; reset to IDLE.
- IDLE:
  - cmd_ready = 1.
  - On accept: register PADDR, PWRITE, PWDATA and PSTRB. PSTRB is forced to 0 for reads.
  - Set PSEL = 1, clear cmd_ready, go to SETUP.
- SETUP: set PENABLE = 1, go to ACCESS, unconditionally.
- ACCESS, PREADY = 0: hold all APB outputs stable (wait state).
- ACCESS, PREADY = 1:
  - rsp_valid = 1, rsp_error = PERROR.
  - rsp_rdata = PRDATA on a read, 0 on a write.
  - Clear PSEL and PENABLE, set cmd_ready, go to IDLE.
- After completion, PADDR, PWRITE, PWDATA and PSTRB hold their last values; no toggling while idle.
- rsp_rdata, rsp_error and rsp_timeout hold until the next completion.
- rsp_valid is high for exactly one cycle per accepted command.
- cmd_* inputs are ignored unless accepted.
- Reset values: every output 0, including cmd_ready.
  - cmd_ready rises on the first PCLK edge after PRESETn deasserts.
- Reset mid-transfer: PSEL and PENABLE drop immediately (asynchronously). No response is issued. The command is lost.

## Timing
- Acceptance at edge e0:
  - PSEL high after e0.
  - PENABLE high after e1.
  - PREADY is first sampled at e2.
- Zero-wait transfer: rsp_valid high during the cycle after e2, two edges after acceptance.
- With k wait states: rsp_valid follows e(2+k).
- cmd_ready is high in the same cycle as rsp_valid. The earliest next accept is e(3+k).
  - PSEL is therefore low for at least one cycle between transfers.
  - Peak throughput is one transfer per 3 cycles.
- Timeout (macro on):
  - Counter cleared on entry to ACCESS; incremented at each ACCESS edge with PREADY = 0.
  - Abort when PREADY = 0 at an edge and count == TIMEOUT_CYCLES-1.
  - On abort: rsp_valid = 1, rsp_error = 1, rsp_timeout = 1, rsp_rdata = 0, bus released, go to IDLE.
  - Counter width: $clog2(TIMEOUT_CYCLES)+1; no wrap.

## Configuration
- APB_REQUESTER_TIMEOUT_EN defined: watchdog compiled in, behaviour as above.
- APB_REQUESTER_TIMEOUT_EN undefined:
  - No counter logic.
  - ACCESS waits indefinitely for PREADY.
  - rsp_timeout is tied 0.

## Structure
- apb_pkg gains:
  - typedef enum logic [1:0] apb_req_state_t {IDLE, SETUP, ACCESS};
  - APB_ADDR_W and APB_DATA_W constants, used as parameter defaults.
- One sub-module, apb_timeout_counter (clear, count-enable, expired output). It is instantiated only under APB_REQUESTER_TIMEOUT_EN.

## Test plan
- Write, zero-wait:
  - Stimulus: addr 0x4, wdata 0xDEADBEEF, strb 0xF, PREADY = 1.
  - Response: PSEL high 2 cycles, PENABLE high 1 cycle, PSTRB = 0xF, rsp_valid 2 edges after accept, rsp_error = 0.
- Read, 3 wait states:
  - Stimulus: addr 0x8, PRDATA 0x12345678.
  - Response: PSTRB = 0 throughout, APB outputs stable in all ACCESS cycles, rsp_valid after edge 5, rsp_rdata = 0x12345678.
- Error: PREADY = 1 with PERROR = 1 on addr 0x40 -> rsp_error = 1, rsp_timeout = 0.
- Back-to-back:
  - Stimulus: cmd_valid held high for two commands.
  - Response: second accepted only at the edge after rsp_valid; PSEL low exactly 1 cycle between the transfers.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 8, PREADY held 0.
  - Macro on: rsp_valid 9 edges after accept, with rsp_error = 1 and rsp_timeout = 1.
  - Macro off: still in ACCESS after 100 cycles.
  - PREADY = 1 on the expiry edge: normal completion, rsp_timeout = 0.
- Reset mid-ACCESS:
  - Stimulus: PRESETn low.
  - Response: all outputs 0 immediately, no rsp_valid; cmd_ready = 1 one edge after release.
